// File: rtl/jtframe_mist_dwnld_pkg.sv
// rtl/jtframe_mist_dwnld_pkg.sv - shared types and bank decode for the ROM download sink
package jtframe_mist_dwnld_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } dwnld_st_t;

  localparam int DATA_W  = 8;
  localparam int BA_W    = 2;
  localparam int ADDR_W  = 22;
  localparam int MASK_W  = 2;
  localparam int ENTRY_W = DATA_W + BA_W + ADDR_W + MASK_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] mask;
  } dwnld_entry_t;

  // Highest bank wins; rel bits above 22 fall off, so oversized banks wrap.
  function automatic dwnld_entry_t bank_decode(
    input logic [24:0] off,
    input logic [7:0]  data,
    input logic [24:0] ba1_start,
    input logic [24:0] ba2_start,
    input logic [24:0] ba3_start
  );
    dwnld_entry_t e;
    logic [24:0]  rel;
    e.data = data;
    if (off >= ba3_start) begin
      e.ba = 2'd3;
      rel  = off - ba3_start;
    end else if (off >= ba2_start) begin
      e.ba = 2'd2;
      rel  = off - ba2_start;
    end else if (off >= ba1_start) begin
      e.ba = 2'd1;
      rel  = off - ba1_start;
    end else begin
      e.ba = 2'd0;
      rel  = off;
    end
    e.addr = 22'(rel >> 1);
    e.mask = rel[0] ? 2'b01 : 2'b10;
    return e;
  endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// rtl/jtframe_dwnld_fifo.sv - single-clock FIFO with registered full/empty flags
module jtframe_dwnld_fifo #(
  parameter int W  = 34,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, cnt_nx;
  logic          do_push, do_pop;

  // Full is the registered flag, so a same-cycle pop never makes room.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    cnt_nx = cnt;
    if (do_push & ~do_pop) cnt_nx = cnt + 1'b1;
    if (do_pop & ~do_push) cnt_nx = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nx;
      full  <= (cnt_nx == DEPTH);
      empty <= (cnt_nx == '0);
    end
  end

endmodule

// File: rtl/jtframe_mist_dwnld.sv
// rtl/jtframe_mist_dwnld.sv - ioctl byte stream to banked, masked SDRAM write requests
module jtframe_mist_dwnld
  import jtframe_mist_dwnld_pkg::*;
#(
  parameter int          HEADER    = 0,
  parameter logic [24:0] BA1_START = 25'h1_0000,
  parameter logic [24:0] BA2_START = 25'h2_0000,
  parameter logic [24:0] BA3_START = 25'h3_0000,
  parameter int          FIFO_AW   = 2
) (
  input  logic        clk_rom,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  input  logic        ioctl_ram,
  input  logic        ioctl_cheat,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  input  logic        prog_ack,
  output logic        header_wr,
  output logic [4:0]  header_addr,
  output logic [7:0]  header_data,
  output logic        dwnld_busy,
  output logic        overflow
);

  dwnld_st_t            st;
  logic [25:0]          off_ext;
  logic                 is_hdr, accept, push, pop;
  logic                 fifo_full, fifo_empty;
  dwnld_entry_t         push_e, head_e;
  logic [ENTRY_W-1:0]   head_bits;

  // The borrow out of addr-HEADER tells header bytes from payload.
  assign off_ext = {1'b0, ioctl_addr} - 26'(HEADER);
  assign is_hdr  = off_ext[25];
  assign accept  = ioctl_wr & downloading & ~ioctl_ram & ~ioctl_cheat;
  assign push    = accept & ~is_hdr & ~fifo_full;
  assign pop     = (st == IDLE || st == GAP) && !fifo_empty;
  assign push_e  = bank_decode(off_ext[24:0], ioctl_dout, BA1_START, BA2_START, BA3_START);
  assign head_e  = head_bits;

  jtframe_dwnld_fifo #(
    .W  (ENTRY_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk_rom),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_e),
    .pop   (pop),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Loading happens on the way into ISSUE so prog_we rises two cycles after the strobe.
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= '0;
      prog_ba   <= '0;
    end else begin
      case (st)
        IDLE, GAP: begin
          if (!fifo_empty) begin
            prog_addr <= head_e.addr;
            prog_data <= {head_e.data, head_e.data};
            prog_mask <= head_e.mask;
            prog_ba   <= head_e.ba;
            prog_we   <= 1'b1;
            st        <= ISSUE;
          end else begin
            st <= IDLE;
          end
        end
        ISSUE: st <= WAIT;
        WAIT: begin
          if (prog_ack) begin
            prog_we <= 1'b0;
            st      <= GAP;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      header_wr   <= 1'b0;
      header_addr <= '0;
      header_data <= '0;
      dwnld_busy  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      header_wr <= accept & is_hdr;
      if (accept & is_hdr) begin
        header_addr <= ioctl_addr[4:0];
        header_data <= ioctl_dout;
      end
      if (accept & ~is_hdr & fifo_full) overflow <= 1'b1;
      if (accept)
        dwnld_busy <= 1'b1;
      else if (st == IDLE && fifo_empty && !downloading)
        dwnld_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_mist_dwnld.sv
// tb/tb_jtframe_mist_dwnld.sv - scoreboard bench for jtframe_mist_dwnld
module tb_jtframe_mist_dwnld;

  localparam int HEADER = 4;

  typedef struct {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } hdr_t;

  logic        clk_rom = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic        ioctl_ram = 1'b0;
  logic        ioctl_cheat = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_ack = 1'b0;
  logic        header_wr;
  logic [4:0]  header_addr;
  logic [7:0]  header_data;
  logic        dwnld_busy;
  logic        overflow;

  int   total = 0;
  int   bad = 0;
  int   nwr = 0;
  int   nhdr = 0;
  int   cyc = 0;
  int   ack_en = 0;
  int   ack_delay = 2;
  int   wcnt = 0;
  logic we_q = 1'b0;
  logic [41:0] held = '0;
  wr_t  exp_q[$];
  hdr_t hdr_q[$];
  int   rise_q[$];

  jtframe_mist_dwnld #(.HEADER(HEADER)) dut (
    .clk_rom     (clk_rom),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .ioctl_ram   (ioctl_ram),
    .ioctl_cheat (ioctl_cheat),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_ba     (prog_ba),
    .prog_we     (prog_we),
    .prog_ack    (prog_ack),
    .header_wr   (header_wr),
    .header_addr (header_addr),
    .header_data (header_data),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  always #5 clk_rom = ~clk_rom;
  always @(posedge clk_rom) cyc <= cyc + 1;

  // SDRAM controller model: acks after ack_delay cycles of prog_we
  initial forever begin
    @(posedge clk_rom); #1;
    if (prog_ack) begin
      prog_ack = 1'b0;
      wcnt = 0;
    end else if (prog_we && ack_en != 0) begin
      wcnt++;
      if (wcnt >= ack_delay) prog_ack = 1'b1;
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk_rom) begin
    if (prog_we && !we_q) begin
      nwr++;
      rise_q.push_back(cyc);
      held = {prog_ba, prog_addr, prog_mask, prog_data};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got ba=%0d addr=%h mask=%b data=%h", prog_ba, prog_addr, prog_mask, prog_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({prog_ba, prog_addr, prog_mask, prog_data} !== {e.ba, e.addr, e.mask, e.data}) begin
          bad++;
          $display("FAIL write got ba=%0d addr=%h mask=%b data=%h expected ba=%0d addr=%h mask=%b data=%h",
                   prog_ba, prog_addr, prog_mask, prog_data, e.ba, e.addr, e.mask, e.data);
        end
      end
    end else if (prog_we && we_q) begin
      total++;
      if ({prog_ba, prog_addr, prog_mask, prog_data} !== held) begin
        bad++;
        $display("FAIL hold got %h expected %h", {prog_ba, prog_addr, prog_mask, prog_data}, held);
      end
    end
    we_q = prog_we;
    if (header_wr) begin
      nhdr++;
      total++;
      if (hdr_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_header got addr=%0d data=%h", header_addr, header_data);
      end else begin
        hdr_t h;
        h = hdr_q.pop_front();
        if ({header_addr, header_data} !== {h.a, h.d}) begin
          bad++;
          $display("FAIL header got addr=%0d data=%h expected addr=%0d data=%h", header_addr, header_data, h.a, h.d);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_rom); #1;
    end
  endtask

  task automatic put(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk_rom); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic exp_wr(input logic [1:0] ba, input logic [21:0] addr, input logic [1:0] mask, input logic [7:0] d);
    wr_t e;
    e.ba = ba; e.addr = addr; e.mask = mask; e.data = {d, d};
    exp_q.push_back(e);
  endtask

  task automatic exp_hdr(input logic [4:0] a, input logic [7:0] d);
    hdr_t h;
    h.a = a; h.d = d;
    hdr_q.push_back(h);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !prog_we) break;
      cycles(1);
    end
    total++;
    if (exp_q.size() != 0 || prog_we) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d prog_we=%b expected 0 0", name, exp_q.size(), prog_we);
    end
  endtask

  task automatic wait_idle(input string name);
    downloading = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!dwnld_busy) break;
      cycles(1);
    end
    total++;
    if (dwnld_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_end got %b expected 0", name, dwnld_busy);
    end
  endtask

  task automatic test_reset;
    cycles(3);
    total++;
    if ({prog_we, dwnld_busy, overflow, header_wr} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got %b expected 0000", {prog_we, dwnld_busy, overflow, header_wr});
    end
    total++;
    if ({prog_addr, prog_data, prog_mask, prog_ba, header_addr, header_data} !== '0) begin
      bad++;
      $display("FAIL reset_data got %h expected 0", {prog_addr, prog_data, prog_mask, prog_ba, header_addr, header_data});
    end
    rst_n = 1'b1;
    cycles(2);
    total++;
    if ({prog_we, dwnld_busy, overflow} !== 3'b0) begin
      bad++;
      $display("FAIL post_reset got %b expected 000", {prog_we, dwnld_busy, overflow});
    end
  endtask

  task automatic test_header;
    logic [7:0] d;
    downloading = 1'b1;
    ack_en = 1;
    for (int i = 0; i < 6; i++) begin
      d = 8'(8'h11 * (i + 1));
      if (i < HEADER) exp_hdr(5'(i), d);
      else exp_wr(2'd0, 22'd0, (i == 4) ? 2'b10 : 2'b01, d);
      put(25'(i), d);
    end
    total++;
    if (dwnld_busy !== 1'b1) begin
      bad++;
      $display("FAIL header_busy got %b expected 1", dwnld_busy);
    end
    wait_drain("header");
    wait_idle("header");
  endtask

  task automatic test_latency;
    downloading = 1'b1;
    exp_wr(2'd0, 22'd3, 2'b10, 8'h9C);
    ioctl_addr = 25'(HEADER + 6);
    ioctl_dout = 8'h9C;
    ioctl_wr   = 1'b1;
    cycles(1);
    ioctl_wr = 1'b0;
    total++;
    if (prog_we !== 1'b0) begin
      bad++;
      $display("FAIL latency_n1 got %b expected 0", prog_we);
    end
    cycles(1);
    total++;
    if (prog_we !== 1'b1) begin
      bad++;
      $display("FAIL latency_n2 got %b expected 1", prog_we);
    end
    wait_drain("latency");
  endtask

  task automatic test_banks;
    logic [24:0] a_t [6];
    logic [7:0]  d_t [6];
    logic [1:0]  ba_t [6];
    logic [21:0] ad_t [6];
    logic [1:0]  m_t [6];
    a_t = '{25'(HEADER) + 25'h2_0003, 25'(HEADER) + 25'h1_0000, 25'(HEADER) + 25'h0_FFFF,
            25'(HEADER) + 25'h3_0001, 25'h183_0008, 25'(HEADER)};
    d_t  = '{8'hA5, 8'h3C, 8'h7E, 8'h81, 8'h5A, 8'h01};
    ba_t = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0};
    ad_t = '{22'd1, 22'd0, 22'h7FFF, 22'd0, 22'd2, 22'd0};
    m_t  = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    downloading = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_wr(ba_t[i], ad_t[i], m_t[i], d_t[i]);
      put(a_t[i], d_t[i]);
      cycles(4);
    end
    wait_drain("banks");
  endtask

  task automatic test_back_to_back;
    int n0;
    downloading = 1'b1;
    ack_en = 0;
    rise_q.delete();
    n0 = nwr;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_wr(2'd0, 22'(i / 2), (i % 2 == 1) ? 2'b01 : 2'b10, 8'(8'h10 + i));
      put(25'(HEADER + i), 8'(8'h10 + i));
    end
    cycles(3);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL b2b_overflow got %b expected 1", overflow);
    end
    total++;
    if (nwr - n0 != 1) begin
      bad++;
      $display("FAIL b2b_stalled_writes got %0d expected 1", nwr - n0);
    end
    ack_en = 1;
    wait_drain("b2b");
    total++;
    if (rise_q.size() != 5) begin
      bad++;
      $display("FAIL b2b_count got %0d expected 5", rise_q.size());
    end else begin
      for (int i = 2; i < 5; i++) begin
        total++;
        if (rise_q[i] - rise_q[i-1] != 3) begin
          bad++;
          $display("FAIL b2b_spacing got %0d expected 3", rise_q[i] - rise_q[i-1]);
        end
      end
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL b2b_sticky got %b expected 1", overflow);
    end
  endtask

  task automatic test_dwnld_end;
    int  n0;
    bit  done;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    downloading = 1'b1;
    ack_en = 0;
    ack_delay = 2;
    n0 = nwr;
    exp_wr(2'd0, 22'd4, 2'b10, 8'hC1);
    exp_wr(2'd0, 22'd4, 2'b01, 8'hC2);
    exp_wr(2'd0, 22'd5, 2'b10, 8'hC3);
    put(25'(HEADER + 8), 8'hC1);
    put(25'(HEADER + 9), 8'hC2);
    put(25'(HEADER + 10), 8'hC3);
    downloading = 1'b0;
    cycles(2);
    total++;
    if (dwnld_busy !== 1'b1) begin
      bad++;
      $display("FAIL end_busy_draining got %b expected 1", dwnld_busy);
    end
    ack_en = 1;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      if (nwr == n0 + 3 && !prog_we) begin
        done = 1;
        break;
      end
      cycles(1);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL end_timeout got writes=%0d expected 3", nwr - n0);
    end else begin
      total++;
      if (dwnld_busy !== 1'b1) begin
        bad++;
        $display("FAIL end_busy_gap got %b expected 1", dwnld_busy);
      end
      cycles(1);
      total++;
      if (dwnld_busy !== 1'b1) begin
        bad++;
        $display("FAIL end_busy_idle got %b expected 1", dwnld_busy);
      end
      cycles(1);
      total++;
      if (dwnld_busy !== 1'b0) begin
        bad++;
        $display("FAIL end_busy_fall got %b expected 0", dwnld_busy);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    downloading = 1'b1;
    ack_en = 0;
    exp_wr(2'd0, 22'd0, 2'b10, 8'h20);
    for (int i = 0; i < 6; i++) put(25'(HEADER + i), 8'(8'h20 + i));
    cycles(2);
    total++;
    if ({prog_we, overflow, dwnld_busy} !== 3'b111) begin
      bad++;
      $display("FAIL mid_pre got %b expected 111", {prog_we, overflow, dwnld_busy});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({prog_we, overflow, dwnld_busy} !== 3'b000) begin
      bad++;
      $display("FAIL mid_async got %b expected 000", {prog_we, overflow, dwnld_busy});
    end
    @(posedge clk_rom); #1;
    rst_n = 1'b1;
    ack_en = 1;
    n0 = nwr;
    cycles(20);
    total++;
    if (nwr != n0) begin
      bad++;
      $display("FAIL mid_no_write got %0d expected 0", nwr - n0);
    end
    exp_wr(2'd0, 22'h10, 2'b10, 8'h4D);
    put(25'(HEADER + 32), 8'h4D);
    wait_drain("mid");
    wait_idle("mid");
  endtask

  task automatic test_ignored;
    int n0, h0;
    n0 = nwr;
    h0 = nhdr;
    downloading = 1'b1;
    ioctl_ram = 1'b1;
    put(25'd1, 8'hE1);
    put(25'(HEADER + 2), 8'hE2);
    ioctl_ram = 1'b0;
    ioctl_cheat = 1'b1;
    put(25'd2, 8'hE3);
    put(25'(HEADER + 3), 8'hE4);
    ioctl_cheat = 1'b0;
    cycles(5);
    total++;
    if ({dwnld_busy, overflow} !== 2'b00) begin
      bad++;
      $display("FAIL ignored_busy got %b expected 00", {dwnld_busy, overflow});
    end
    total++;
    if (nwr != n0 || nhdr != h0) begin
      bad++;
      $display("FAIL ignored_strobes got wr=%0d hdr=%0d expected 0 0", nwr - n0, nhdr - h0);
    end
    downloading = 1'b0;
  endtask

  initial begin
    #1;
    test_reset;
    test_header;
    test_latency;
    test_banks;
    test_back_to_back;
    test_dwnld_end;
    test_reset_mid;
    test_ignored;
    cycles(3);
    total++;
    if (exp_q.size() != 0 || hdr_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got writes=%0d headers=%0d expected 0 0", exp_q.size(), hdr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
